// File: rtl/encoder42.sv
// encoder42: registered 4-to-2 priority encoder.
// Primarily for one-hot requests. Overlapping requests resolve to the highest
// index and raise multi. valid separates "line 0 requested" from "no request".
module encoder42 (
  input  logic clk,
  input  logic rst,
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  output logic y1,
  output logic y0,
  output logic valid,
  output logic multi
);

  logic [3:0] req;
  logic [1:0] idx_d, idx_q;
  logic       valid_d, valid_q;
  logic       multi_d, multi_q;

  assign req = {i3, i2, i1, i0};

  // Next-state: priority index, any-request flag and overlap detection.
  always_comb begin
    idx_d   = 2'b00;
    valid_d = |req;
    // Two or more bits set means the vector with its lowest set bit cleared
    // is still non-zero.
    multi_d = |(req & (req - 4'd1));
    if (req[3])      idx_d = 2'b11;
    else if (req[2]) idx_d = 2'b10;
    else if (req[1]) idx_d = 2'b01;
    else             idx_d = 2'b00;
  end

  // Output registers; reset discards whatever inputs are sampled on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 2'b00;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign y1    = idx_q[1];
  assign y0    = idx_q[0];
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_encoder42.sv
// Bench for encoder42: directed plan items plus randomized traffic, each
// result compared against a behavioural model of the encoding rules.
module tb_encoder42;

  logic clk;
  logic rst;
  logic i0, i1, i2, i3;
  logic y1, y0, valid, multi;

  int total = 0;
  int bad   = 0;

  encoder42 dut (
    .clk   (clk),
    .rst   (rst),
    .i0    (i0),
    .i1    (i1),
    .i2    (i2),
    .i3    (i3),
    .y1    (y1),
    .y0    (y0),
    .valid (valid),
    .multi (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {y1,y0,valid,multi} for one sampled edge; v[k] is request line k.
  function automatic logic [3:0] ref_out(input bit r, input bit [3:0] v);
    int hi;
    int cnt;
    logic [1:0] idx;
    hi  = 0;
    cnt = 0;
    if (r) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (v[k]) begin
        hi  = k;
        cnt = cnt + 1;
      end
    end
    idx = hi[1:0];
    return {idx, cnt > 0, cnt > 1};
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got y1y0/valid/multi=%b required=%b", tag, got, exp);
    end
  endtask

  task automatic drive(input bit r, input bit [3:0] v);
    rst = r;
    i0  = v[0];
    i1  = v[1];
    i2  = v[2];
    i3  = v[3];
  endtask

  // Apply one vector for one edge, check after the edge, then disturb the
  // inputs mid-cycle and confirm the outputs hold until the next edge.
  task automatic step(input string tag, input bit r, input bit [3:0] v);
    logic [3:0] exp;
    bit [3:0] junk;
    @(negedge clk);
    drive(r, v);
    exp = ref_out(r, v);
    @(posedge clk);
    #1;
    chk(tag, {y1, y0, valid, multi}, exp);
    junk = 4'($urandom);
    drive(r, ~v ^ junk);
    #2;
    chk({tag, "_hold"}, {y1, y0, valid, multi}, exp);
  endtask

  initial begin
    drive(1'b1, 4'b1000);

    // Reset dominates even with i3 asserted
    step("rst0", 1'b1, 4'b1000);
    step("rst1", 1'b1, 4'b1000);

    // One-hot sweep
    step("oh_i0", 1'b0, 4'b0001);
    step("oh_i1", 1'b0, 4'b0010);
    step("oh_i2", 1'b0, 4'b0100);
    step("oh_i3", 1'b0, 4'b1000);

    // No request
    step("zero", 1'b0, 4'b0000);

    // Overlapping requests
    step("mh_i0i2", 1'b0, 4'b0101);
    step("mh_all",  1'b0, 4'b1111);

    // Mid-stream reset discards the vector sampled on the reset edge
    step("mid_pre",  1'b0, 4'b1000);
    step("mid_rst",  1'b1, 4'b0100);
    step("mid_post", 1'b0, 4'b0100);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 300; n++) begin
      step("rand", ($urandom_range(0, 15) == 0), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encoder42.md
Name: encoder42

Overview:
- Registered 4-to-2 binary encoder. Four single-bit request lines in; 2-bit index of the asserted line out.
- Primary use is one-hot inputs. Non-one-hot inputs are resolved by fixed priority (highest index wins) and flagged.
- Sits between one-hot select/request logic and downstream binary-indexed logic.
- Outputs are registered on a single clock, with a synchronous active-high reset.

Parameters:
- none (fixed 4-input, 2-output encoder)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- i0  input  1  request line 0 (lowest priority)
- i1  input  1  request line 1
- i2  input  1  request line 2
- i3  input  1  request line 3 (highest priority)
- y1  output  1  encoded index, MSB (registered)
- y0  output  1  encoded index, LSB (registered)
- valid  output  1  registered; 1 when at least one input was asserted
- multi  output  1  registered; 1 when more than one input was asserted

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). The polarity and synchronicity are fixed.
- Reset:
  - On a rising clk edge with rst=1: y1=0, y0=0, valid=0, multi=0.
  - Reset takes precedence over any input state.
  - Reset asserted mid-stream clears the outputs at that edge. Inputs sampled on that edge are discarded.
- Latency: exactly 1 cycle. The inputs sampled at edge N appear on the outputs after edge N and hold until edge N+1. No combinational path from inputs to outputs.
- Encoding, evaluated on each rising edge with rst=0:
  - i3=1 -> {y1,y0}=11
  - else i2=1 -> 10
  - else i1=1 -> 01
  - else i0=1 -> 00
  - all zero -> 00
- valid = i0|i1|i2|i3, sampled on the same edge.
  - Distinguishes "i0 asserted" (00, valid=1) from "none asserted" (00, valid=0).
- multi = 1 when two or more inputs are 1 on the sampled edge, else 0.
  - When multi=1, {y1,y0} still follows the priority rule above.
- Handshake: none. The block samples its inputs on every edge; there is no enable or stall.
- Outputs hold their last registered value between edges.
- X/Z on inputs is not handled specially; the bench drives only 0/1.

Test Plan:
- Reset: rst=1 for 2 cycles with i3=1 -> y1=0, y0=0, valid=0, multi=0 after each edge.
- One-hot sweep, one cycle each, rst=0: (i0..i3)=1000 -> 00; 0100 -> 01; 0010 -> 10; 0001 -> 11. Each result appears one edge after it is applied, with valid=1 and multi=0.
- All-zero input -> y=00, valid=0, multi=0.
- Multi-hot:
  - i0=1, i2=1 -> y=10, valid=1, multi=1.
  - all four high -> y=11, valid=1, multi=1.
- Mid-stream reset: drive 0001 (y=11), then assert rst for one edge with 0100 applied -> outputs all 0. Deassert rst while holding 0100 -> y=01, valid=1 on the next edge.
- Latency check: change the inputs between edges. Outputs must not change until the next rising clk.
